// File: rtl/dmem_port_arbiter_if.sv
// Bundles the core, debug and memory sides of the data-memory port arbiter.
// The slave modport is the arbiter view; master is the surrounding environment.
interface dmem_port_arbiter_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
);
  logic              core_req;
  logic              core_we;
  logic [ADDR_W-1:0] core_addr;
  logic [DATA_W-1:0] core_wdata;
  logic              core_stall;
  logic [DATA_W-1:0] core_rdata;
  logic              core_rvalid;

  logic              dbg_req;
  logic              dbg_we;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata;
  logic              dbg_gnt;
  logic [DATA_W-1:0] dbg_rdata;
  logic              dbg_rvalid;

  logic              mem_we;
  logic              mem_re;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  core_req, core_we, core_addr, core_wdata,
    output core_stall, core_rdata, core_rvalid,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output dbg_gnt, dbg_rdata, dbg_rvalid,
    output mem_we, mem_re, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output core_req, core_we, core_addr, core_wdata,
    input  core_stall, core_rdata, core_rvalid,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  dbg_gnt, dbg_rdata, dbg_rvalid,
    input  mem_we, mem_re, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Single-port data memory arbiter: core has priority, debug is forced through
// after STARVE_MAX consecutive denied cycles. Read data returns one cycle later.
module dmem_port_arbiter #(
  parameter int ADDR_W     = 6,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic               clk,
  input  logic               reset,
  dmem_port_arbiter_if.slave bus
);
  localparam int CW = $clog2(STARVE_MAX + 1);

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } acc_t;

  acc_t              core_acc, dbg_acc, sel;
  logic [CW-1:0]     starve_cnt;
  logic              force_dbg, core_gnt, dbg_gnt, any_gnt;
  logic              core_rvalid_q, dbg_rvalid_q;
  logic [DATA_W-1:0] core_rdata_q, dbg_rdata_q;

  assign core_acc = '{we: bus.core_we, addr: bus.core_addr, wdata: bus.core_wdata};
  assign dbg_acc  = '{we: bus.dbg_we,  addr: bus.dbg_addr,  wdata: bus.dbg_wdata};

  assign force_dbg = bus.dbg_req && (starve_cnt == CW'(STARVE_MAX));
  assign core_gnt  = bus.core_req && !force_dbg;
  assign dbg_gnt   = force_dbg || (bus.dbg_req && !bus.core_req);
  assign any_gnt   = core_gnt || dbg_gnt;

  always_comb begin
    sel = '0;
    if (core_gnt)     sel = core_acc;
    else if (dbg_gnt) sel = dbg_acc;
  end

  // Unused address/data are forced to zero so an idle bus is quiet.
  assign bus.mem_we     = any_gnt && sel.we;
  assign bus.mem_re     = any_gnt && !sel.we;
  assign bus.mem_addr   = sel.addr;
  assign bus.mem_wdata  = sel.wdata;
  assign bus.core_stall = bus.core_req && !core_gnt;
  assign bus.dbg_gnt    = dbg_gnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_cnt <= '0;
    end else if (!bus.dbg_req || dbg_gnt) begin
      starve_cnt <= '0;
    end else if (starve_cnt != CW'(STARVE_MAX)) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  // Reset drops any in-flight return so no rvalid appears after release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      core_rvalid_q <= 1'b0;
      dbg_rvalid_q  <= 1'b0;
      core_rdata_q  <= '0;
      dbg_rdata_q   <= '0;
    end else begin
      core_rvalid_q <= core_gnt && !bus.core_we;
      dbg_rvalid_q  <= dbg_gnt && !bus.dbg_we;
      if (core_gnt && !bus.core_we) core_rdata_q <= bus.mem_rdata;
      if (dbg_gnt && !bus.dbg_we)   dbg_rdata_q  <= bus.mem_rdata;
    end
  end

  assign bus.core_rvalid = core_rvalid_q;
  assign bus.core_rdata  = core_rdata_q;
  assign bus.dbg_rvalid  = dbg_rvalid_q;
  assign bus.dbg_rdata   = dbg_rdata_q;
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed vector bench for dmem_port_arbiter with a behavioural 64-word memory.
module tb_dmem_port_arbiter;
  localparam int ADDR_W = 6;
  localparam int DATA_W = 32;
  localparam int NV     = 33;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dmem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  dmem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [DATA_W-1:0] tmem [64];
  initial for (int i = 0; i < 64; i++) tmem[i] = '0;
  always @(posedge clk) if (bus.mem_we) tmem[bus.mem_addr] <= bus.mem_wdata;
  assign bus.mem_rdata = tmem[bus.mem_addr];

  typedef struct {
    logic        creq, cwe;
    logic [5:0]  caddr;
    logic [31:0] cwd;
    logic        dreq, dwe;
    logic [5:0]  daddr;
    logic [31:0] dwd;
    logic        stall, dgnt, mwe, mre;
    logic [5:0]  maddr;
    logic [31:0] mwd;
    logic        crv;
    logic [31:0] crd;
    logic        drv;
    logic [31:0] drd;
  } vec_t;

  vec_t tbl [NV];
  int n_chk = 0;
  int n_fail = 0;

  function automatic vec_t v(
    logic creq, logic cwe, logic [5:0] caddr, logic [31:0] cwd,
    logic dreq, logic dwe, logic [5:0] daddr, logic [31:0] dwd,
    logic stall, logic dgnt, logic mwe, logic mre, logic [5:0] maddr, logic [31:0] mwd,
    logic crv, logic [31:0] crd, logic drv, logic [31:0] drd);
    vec_t r;
    r.creq = creq; r.cwe = cwe; r.caddr = caddr; r.cwd = cwd;
    r.dreq = dreq; r.dwe = dwe; r.daddr = daddr; r.dwd = dwd;
    r.stall = stall; r.dgnt = dgnt; r.mwe = mwe; r.mre = mre; r.maddr = maddr; r.mwd = mwd;
    r.crv = crv; r.crd = crd; r.drv = drv; r.drd = drd;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t t);
    bus.core_req = t.creq; bus.core_we = t.cwe; bus.core_addr = t.caddr; bus.core_wdata = t.cwd;
    bus.dbg_req  = t.dreq; bus.dbg_we  = t.dwe; bus.dbg_addr  = t.daddr; bus.dbg_wdata  = t.dwd;
  endtask

  task automatic check_all(input string tag, input vec_t t);
    chk({tag, " core_stall"},  32'(bus.core_stall),  32'(t.stall));
    chk({tag, " dbg_gnt"},     32'(bus.dbg_gnt),     32'(t.dgnt));
    chk({tag, " mem_we"},      32'(bus.mem_we),      32'(t.mwe));
    chk({tag, " mem_re"},      32'(bus.mem_re),      32'(t.mre));
    chk({tag, " mem_addr"},    32'(bus.mem_addr),    32'(t.maddr));
    chk({tag, " mem_wdata"},   bus.mem_wdata,        t.mwd);
    chk({tag, " core_rvalid"}, 32'(bus.core_rvalid), 32'(t.crv));
    chk({tag, " core_rdata"},  bus.core_rdata,       t.crd);
    chk({tag, " dbg_rvalid"},  32'(bus.dbg_rvalid),  32'(t.drv));
    chk({tag, " dbg_rdata"},   bus.dbg_rdata,        t.drd);
  endtask

  initial begin
    vec_t idle, both, force9, core1, crd1, cont2, force2;
    idle = v(0,0,0,0, 0,0,0,0, 0,0,0,0,0,0, 0,0, 0,0);

    // Core write then read of addr 5.
    tbl[0]  = idle;
    tbl[1]  = v(1,1,5,32'hDEADBEEF, 0,0,0,0, 0,0,1,0,5,32'hDEADBEEF, 0,0, 0,0);
    tbl[2]  = v(1,0,5,0, 0,0,0,0, 0,0,0,1,5,0, 0,0, 0,0);
    tbl[3]  = v(0,0,0,0, 0,0,0,0, 0,0,0,0,0,0, 1,32'hDEADBEEF, 0,0);
    // Debug-only load on consecutive cycles.
    tbl[4]  = v(0,0,0,0, 1,1,0,32'h100, 0,1,1,0,0,32'h100, 0,32'hDEADBEEF, 0,0);
    tbl[5]  = v(0,0,0,0, 1,1,1,32'h101, 0,1,1,0,1,32'h101, 0,32'hDEADBEEF, 0,0);
    tbl[6]  = v(0,0,0,0, 1,1,2,32'h102, 0,1,1,0,2,32'h102, 0,32'hDEADBEEF, 0,0);
    tbl[7]  = v(0,0,0,0, 1,1,3,32'h103, 0,1,1,0,3,32'h103, 0,32'hDEADBEEF, 0,0);
    tbl[8]  = v(0,0,0,0, 1,1,9,32'h99,  0,1,1,0,9,32'h99,  0,32'hDEADBEEF, 0,0);
    // Contention: core reads 1, debug reads 9; debug forced on the 5th cycle.
    tbl[9]  = v(1,0,1,0, 1,0,9,0, 0,0,0,1,1,0, 0,32'hDEADBEEF, 0,0);
    both    = v(1,0,1,0, 1,0,9,0, 0,0,0,1,1,0, 1,32'h101, 0,0);
    tbl[10] = both; tbl[11] = both; tbl[12] = both;
    force9  = v(1,0,1,0, 1,0,9,0, 1,1,0,1,9,0, 1,32'h101, 0,0);
    tbl[13] = force9;
    tbl[14] = v(1,0,1,0, 1,0,9,0, 0,0,0,1,1,0, 0,32'h101, 1,32'h99);
    core1   = v(1,0,1,0, 1,0,9,0, 0,0,0,1,1,0, 1,32'h101, 0,32'h99);
    tbl[15] = core1; tbl[16] = core1; tbl[17] = core1;
    force9.drd = 32'h99;
    tbl[18] = force9;
    // Counter clear: 3 denied, 1 idle, then 4 more denied before forcing.
    tbl[19] = v(1,0,1,0, 0,0,0,0, 0,0,0,1,1,0, 0,32'h101, 1,32'h99);
    cont2   = v(1,0,1,0, 1,0,2,0, 0,0,0,1,1,0, 1,32'h101, 0,32'h99);
    tbl[20] = cont2; tbl[21] = cont2; tbl[22] = cont2;
    crd1    = v(1,0,1,0, 0,0,0,0, 0,0,0,1,1,0, 1,32'h101, 0,32'h99);
    tbl[23] = crd1;
    tbl[24] = cont2; tbl[25] = cont2; tbl[26] = cont2; tbl[27] = cont2;
    force2  = v(1,0,1,0, 1,0,2,0, 1,1,0,1,2,0, 1,32'h101, 0,32'h99);
    tbl[28] = force2;
    tbl[29] = v(0,0,0,0, 0,0,0,0, 0,0,0,0,0,0, 0,32'h101, 1,32'h102);
    // Same address: core write wins, debug read next cycle sees it.
    tbl[30] = v(1,1,3,32'hC3, 1,0,3,0, 0,0,1,0,3,32'hC3, 0,32'h101, 0,32'h102);
    tbl[31] = v(0,0,0,0, 1,0,3,0, 0,1,0,1,3,0, 0,32'h101, 0,32'h102);
    tbl[32] = v(0,0,0,0, 0,0,0,0, 0,0,0,0,0,0, 0,32'h101, 1,32'hC3);

    // Reset then idle.
    reset = 1'b0;
    drive(idle);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all("rst", idle);
    @(posedge clk); #1 reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check_all($sformatf("post_rst%0d", i), idle);
      @(posedge clk); #1;
    end

    for (int i = 0; i < NV; i++) begin
      drive(tbl[i]);
      @(negedge clk);
      check_all($sformatf("v%0d", i), tbl[i]);
      @(posedge clk); #1;
    end

    // Reset lands between a granted core read and its capture edge.
    drive(v(1,0,5,0, 0,0,0,0, 0,0,0,0,0,0, 0,0, 0,0));
    @(negedge clk);
    chk("midrd mem_re", 32'(bus.mem_re), 32'd1);
    #2 reset = 1'b0;
    @(posedge clk); #1;
    drive(idle);
    chk("midrd rvalid in reset", 32'(bus.core_rvalid), 32'd0);
    chk("midrd rdata in reset",  bus.core_rdata, 32'd0);
    @(posedge clk); #1 reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check_all($sformatf("midrd_post%0d", i), idle);
      @(posedge clk); #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
